// File: rtl/bloco_operativo.sv
// Operative block of a 16-bit polynomial evaluator.
// Holds X, the accumulator Hr and the result S. Each cycle it forms one
// multiply-add step (md * X +/- ad) and routes it through the output mux to
// whichever registers the external controller enables. A Horner sequence of
// LX / LH / LH / LS produces A*x^2 + B*x + C in S.
module bloco_operativo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [7:0]  K,
  input  logic        LX,
  input  logic        LH,
  input  logic        LS,
  input  logic [1:0]  M0,
  input  logic [1:0]  M1,
  input  logic [1:0]  M2,
  input  logic        H,
  output logic [15:0] resultado
);

  logic [15:0] x_q;
  logic [15:0] hr_q;
  logic [15:0] s_q;

  logic [15:0] ad;
  logic [15:0] md;
  logic [15:0] p;
  logic [15:0] s;
  logic [15:0] y;

  // Combinational datapath: addend/multiplicand muxes, truncated product,
  // add/subtract and ALU output select. Everything is computed from the
  // current register contents, so simultaneous loads all see pre-edge values.
  always_comb begin
    ad = 16'h0000;
    md = 16'h0000;
    p  = 16'h0000;
    s  = 16'h0000;
    y  = 16'h0000;

    case (M0)
      2'b00:   ad = A;
      2'b01:   ad = B;
      2'b10:   ad = C;
      default: ad = 16'h0000;
    endcase

    case (M1)
      2'b00:   md = x_q;
      2'b01:   md = hr_q;
      2'b10:   md = A;
      default: md = 16'h0001;
    endcase

    // 16-bit context keeps only the low half of the 32-bit product.
    p = md * x_q;

    // Two's-complement wrap in both directions, no flags.
    if (H) s = p + ad;
    else   s = p - ad;

    case (M2)
      2'b00:   y = s;
      2'b01:   y = md;
      2'b10:   y = p;
      default: y = ad;
    endcase
  end

  // Register bank: independent enables, asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= 16'h0000;
      hr_q <= 16'h0000;
      s_q  <= 16'h0000;
    end else begin
      if (LX) x_q  <= {8'h00, K};
      if (LH) hr_q <= y;
      if (LS) s_q  <= y;
    end
  end

  assign resultado = s_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Bench for bloco_operativo: directed vector table, hand-written reset and
// hold sequences, then randomized cycles checked against an arithmetic model.
module tb_bloco_operativo;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [7:0]  k;
  logic        lx;
  logic        lh;
  logic        ls;
  logic [1:0]  m0;
  logic [1:0]  m1;
  logic [1:0]  m2;
  logic        h;
  logic [15:0] resultado;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int unsigned mx;
  int unsigned mh;
  int unsigned ms;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  k;
    logic        lx;
    logic        lh;
    logic        ls;
    logic [1:0]  m0;
    logic [1:0]  m1;
    logic [1:0]  m2;
    logic        h;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  bloco_operativo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .C         (c),
    .K         (k),
    .LX        (lx),
    .LH        (lh),
    .LS        (ls),
    .M0        (m0),
    .M1        (m1),
    .M2        (m2),
    .H         (h),
    .resultado (resultado)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: resultado=%h expected=%h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vc,
                              input logic [7:0] vk, input logic vlx, input logic vlh, input logic vls,
                              input logic [1:0] vm0, input logic [1:0] vm1, input logic [1:0] vm2,
                              input logic vh, input logic [15:0] vexp, input string vname);
    vec_t v;
    v.a = va; v.b = vb; v.c = vc; v.k = vk;
    v.lx = vlx; v.lh = vlh; v.ls = vls;
    v.m0 = vm0; v.m1 = vm1; v.m2 = vm2; v.h = vh;
    v.exp = vexp; v.name = vname;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a = v.a; b = v.b; c = v.c; k = v.k;
    lx = v.lx; lh = v.lh; ls = v.ls;
    m0 = v.m0; m1 = v.m1; m2 = v.m2; h = v.h;
  endtask

  // Arithmetic reference: value offered to the registers this cycle.
  function automatic int unsigned model_y(input int unsigned x, input int unsigned hr);
    longint unsigned addend, mult, prod, sum;
    addend = (m0 == 2'd0) ? a : (m0 == 2'd1) ? b : (m0 == 2'd2) ? c : 0;
    mult   = (m1 == 2'd0) ? x : (m1 == 2'd1) ? hr : (m1 == 2'd2) ? a : 1;
    prod   = (mult * x) % 65536;
    if (h) sum = (prod + addend) % 65536;
    else   sum = (prod + 65536 - addend) % 65536;
    case (m2)
      2'd0:    return int'(sum);
      2'd1:    return int'(mult);
      2'd2:    return int'(prod);
      default: return int'(addend);
    endcase
  endfunction

  initial begin
    // Reset block
    rst_n = 1'b0;
    a = 16'h1111; b = 16'h2222; c = 16'h3333; k = 8'h44;
    lx = 1'b1; lh = 1'b1; ls = 1'b1;
    m0 = 2'd0; m1 = 2'd0; m2 = 2'd3; h = 1'b1;
    #1;
    check("reset_async", resultado, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", resultado, 16'h0000);
    lx = 1'b0; lh = 1'b0; ls = 1'b0;
    rst_n = 1'b1;

    // Directed table (state carries from row to row)
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 1,0,0, 2'd0,2'd1,2'd0, 1, 16'd0,    "horner_lx"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,1,0, 2'd0,2'd1,2'd0, 1, 16'd0,    "horner_h_a"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,1,0, 2'd1,2'd1,2'd0, 1, 16'd0,    "horner_h_axb"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,0,1, 2'd2,2'd1,2'd0, 1, 16'h0031, "horner_result"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,0,1, 2'd3,2'd1,2'd1, 1, 16'd11,   "peek_hr"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,0,1, 2'd3,2'd3,2'd2, 1, 16'd4,    "peek_x"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,1,0, 2'd3,2'd0,2'd3, 1, 16'd4,    "clear_hr_hold_s"));
    vecs.push_back(mk(16'd2, 16'd3, 16'd5, 8'd4, 0,0,1, 2'd1,2'd1,2'd0, 0, 16'hFFFD, "subtract_wrap"));
    vecs.push_back(mk(16'h4000, 16'd3, 16'd5, 8'd8, 1,0,0, 2'd0,2'd0,2'd0, 1, 16'hFFFD, "load_x8"));
    vecs.push_back(mk(16'h4000, 16'd3, 16'd5, 8'd8, 0,0,1, 2'd0,2'd2,2'd2, 1, 16'h0000, "trunc_4000"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'd5, 8'd8, 0,0,1, 2'd0,2'd2,2'd2, 1, 16'h0008, "trunc_4001"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'd5, 8'd8, 0,0,1, 2'd0,2'd3,2'd1, 1, 16'h0001, "md_const_one"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'd5, 8'd8, 0,0,1, 2'd3,2'd0,2'd3, 1, 16'h0000, "ad_zero"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'hBEEF, 8'd8, 0,0,1, 2'd2,2'd0,2'd3, 1, 16'hBEEF, "ad_c"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'hBEEF, 8'd8, 0,1,1, 2'd2,2'd1,2'd0, 1, 16'hBEEF, "dual_load_1"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'h0001, 8'd8, 0,1,1, 2'd2,2'd1,2'd0, 1, 16'hF779, "dual_load_2"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'h0001, 8'd8, 0,0,1, 2'd2,2'd1,2'd1, 1, 16'hF779, "dual_hr_match"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'h0001, 8'd3, 1,0,1, 2'd0,2'd3,2'd2, 1, 16'h0008, "lx_ls_old_x"));
    vecs.push_back(mk(16'h4001, 16'd3, 16'h0001, 8'd3, 0,0,1, 2'd0,2'd3,2'd2, 1, 16'h0003, "new_x"));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check(vecs[i].name, resultado, vecs[i].exp);
    end

    // Mid-sequence reset with all loads asserted and nonzero operands
    @(negedge clk);
    a = 16'h0007; k = 8'h09; lx = 1'b1; lh = 1'b1; ls = 1'b1;
    m0 = 2'd0; m2 = 2'd3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_async", resultado, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_held", resultado, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    lx = 1'b0; lh = 1'b0; ls = 1'b1; m1 = 2'd3; m2 = 2'd2;
    @(posedge clk);
    #1;
    check("reset_x_zero", resultado, 16'h0000);
    m1 = 2'd1; m2 = 2'd1;
    @(posedge clk);
    #1;
    check("reset_hr_zero", resultado, 16'h0000);

    // Hold: load a value, then enables low with toggling inputs
    a = 16'h1234; m0 = 2'd0; m2 = 2'd3;
    @(posedge clk);
    #1;
    check("hold_load", resultado, 16'h1234);
    ls = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); k = 8'($urandom);
      m0 = 2'($urandom); m1 = 2'($urandom); m2 = 2'($urandom); h = 1'($urandom);
      @(posedge clk);
      #1;
      check("hold", resultado, 16'h1234);
    end

    // Randomized cycles against the model; X and Hr are known zero here
    mx = 0; mh = 0; ms = 32'h1234;
    for (int i = 0; i < 400; i++) begin
      int unsigned y, nx, nh, ns;
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mx = 0; mh = 0; ms = 0;
        check("rand_reset", resultado, 16'h0000);
        #1;
        rst_n = 1'b1;
      end
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); k = 8'($urandom);
      lx = 1'($urandom); lh = 1'($urandom); ls = 1'($urandom);
      m0 = 2'($urandom); m1 = 2'($urandom); m2 = 2'($urandom);
      h = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 3)) << 14;
      y  = model_y(mx, mh);
      nx = lx ? int'(k) : mx;
      nh = lh ? y : mh;
      ns = ls ? y : ms;
      @(posedge clk);
      #1;
      mx = nx; mh = nh; ms = ns;
      check("random", resultado, 16'(ms));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
